final_soc_frame_cmd: RTL and testbench

FINAL_SOC_FRAME_CMD -- requirements
Module: final_soc_frame_cmd

---
 rtl/final_soc_frame_cmd.sv | 148 ++++++++++++++
 tb/tb_final_soc_frame_cmd.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/final_soc_frame_cmd.sv
// Avalon-MM command port: DATA word driven out with a req/ack four-phase handshake, done/timeout flags and irq.
// Latency: readdata one cycle after address; req rises the cycle after a LAUNCH write; ack sampled through 2 flops.
// Backpressure: none on the bus (no wait states); DATA and LAUNCH writes are dropped while a handshake is busy.
module final_soc_frame_cmd #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  req,
    input  logic                  ack,
    output logic                  irq
);

    // Counter only ever holds 0..TIMEOUT-1.
    localparam int                CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_req;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_done;
    logic                    r_timeout;
    logic                    r_irq_en;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [31:0]             r_readdata;
    logic                    r_ack_meta;
    logic                    r_ack_s;

    logic                    w_wr;
    logic                    w_busy;
    logic                    w_wr_data;
    logic                    w_wr_ctrl;
    logic                    w_wr_status;
    logic                    w_launch;
    logic                    w_unused;

    assign w_wr        = chipselect & ~write_n;
    assign w_busy      = (r_state != IDLE);
    assign w_wr_data   = w_wr & (address == 2'd0) & ~w_busy;
    assign w_wr_ctrl   = w_wr & (address == 2'd1);
    assign w_wr_status = w_wr & (address == 2'd2);
    assign w_launch    = w_wr & (address == 2'd3) & writedata[0] & ~w_busy;
    // Upper writedata bits have no register behind them.
    assign w_unused    = ^writedata;

    assign out_port = r_data;
    assign req      = r_req;
    assign readdata = r_readdata;
    // Pure AND of flops, so irq cannot glitch and is 0 throughout reset.
    assign irq      = r_irq_en & (r_done | r_timeout);

    // ack comes from another clock domain: two-flop synchronizer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    // DATA and CTRL registers; DATA frozen while busy so out_port holds across the handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= '0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_wr_data) r_data   <= writedata[DATA_WIDTH-1:0];
            if (w_wr_ctrl) r_irq_en <= writedata[0];
        end
    end

    // Read mux registered every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= '0;
            case (address)
                2'd0:    r_readdata[DATA_WIDTH-1:0] <= r_data;
                2'd1:    r_readdata[0]   <= r_irq_en;
                2'd2:    r_readdata[2:0] <= {r_timeout, r_done, w_busy};
                default: r_readdata <= '0;
            endcase
        end
    end

    // Handshake FSM with registered req; flag clears come first so an FSM set in the same cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_wr_status && writedata[1]) r_done    <= 1'b0;
            if (w_wr_status && writedata[2]) r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                REQ: begin
                    if (r_ack_s) begin
                        r_state <= RELEASE;
                        r_req   <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= IDLE;
                        r_req     <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    r_req <= 1'b0;
                    if (!r_ack_s) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_final_soc_frame_cmd.sv
// Directed bench for final_soc_frame_cmd (TIMEOUT=16): register access, handshake, timeout, busy lockout, reset.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
// ack is modelled as a hardware responder driven directly from the bench.
module tb_final_soc_frame_cmd;

    localparam int DATA_WIDTH = 8;
    localparam int TIMEOUT    = 16;

    logic                  clk;
    logic                  reset_n;
    logic [1:0]            address;
    logic                  chipselect;
    logic                  write_n;
    logic [31:0]           writedata;
    logic [31:0]           readdata;
    logic [DATA_WIDTH-1:0] out_port;
    logic                  req;
    logic                  ack;
    logic                  irq;

    int n_checks = 0;
    int n_pass   = 0;

    final_soc_frame_cmd #(
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .req        (req),
        .ack        (ack),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    // Counts cycles req stays high after a LAUNCH write, bounded.
    task automatic count_req(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!req) break;
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          n;
        int          req_seen;

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        ack        = 1'b0;
        tick();
        tick();
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_out_port", {24'h0, out_port}, 32'h0);
        chk("reset_req", {31'h0, req}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        tick();

        // DATA write and readback; unused addresses
        bus_wr(2'd0, 32'hFFFF_FF5A);
        chk("data_out_port", {24'h0, out_port}, 32'h5A);
        bus_rd(2'd0, rd);
        chk("data_read", rd, 32'h0000_005A);
        bus_rd(2'd3, rd);
        chk("launch_reads_zero", rd, 32'h0);
        bus_wr(2'd1, 32'h1);
        bus_rd(2'd1, rd);
        chk("ctrl_read", rd, 32'h1);
        chk("irq_idle", {31'h0, irq}, 32'h0);

        // LAUNCH with bit0 clear is ignored
        bus_wr(2'd3, 32'h2);
        chk("launch0_no_req", {31'h0, req}, 32'h0);
        bus_rd(2'd2, rd);
        chk("launch0_status", rd, 32'h0);

        // Full handshake; busy lockout of DATA and LAUNCH
        bus_wr(2'd3, 32'h1);
        chk("launch_req", {31'h0, req}, 32'h1);
        bus_wr(2'd0, 32'hFF);
        bus_wr(2'd3, 32'h1);
        bus_rd(2'd2, rd);
        chk("busy_status", rd, 32'h1);
        tick();
        ack = 1'b1;                     // 4 cycles after req rose
        n = 0;
        do begin
            tick();
            n++;
        end while (req && n < 10);
        // two synchronizer flops plus the registered FSM step
        chk("ack_to_req_fall", n, 3);
        chk("busy_data_locked", {24'h0, out_port}, 32'h5A);
        ack = 1'b0;
        tick();
        tick();
        // done sets on the next edge; clear it in that very cycle
        bus_wr(2'd2, 32'h2);
        bus_rd(2'd2, rd);
        chk("done_set_wins", rd, 32'h2);
        chk("done_irq", {31'h0, irq}, 32'h1);
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (req) req_seen++;
            tick();
        end
        chk("no_second_handshake", req_seen, 0);
        bus_wr(2'd2, 32'h2);
        bus_rd(2'd2, rd);
        chk("done_w1c", rd, 32'h0);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // Timeout with ack held low
        bus_wr(2'd3, 32'h1);
        count_req(n);
        chk("timeout_req_cycles", n, TIMEOUT);
        bus_rd(2'd2, rd);
        chk("timeout_status", rd, 32'h4);
        chk("timeout_irq", {31'h0, irq}, 32'h1);
        bus_wr(2'd2, 32'h4);
        bus_rd(2'd2, rd);
        chk("timeout_w1c", rd, 32'h0);

        // Second timeout leaves the flag set, then reset mid-handshake
        bus_wr(2'd3, 32'h1);
        count_req(n);
        chk("timeout2_req_cycles", n, TIMEOUT);
        bus_wr(2'd3, 32'h1);
        tick();
        tick();
        chk("pre_reset_req", {31'h0, req}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_req", {31'h0, req}, 32'h0);
        chk("async_reset_irq", {31'h0, irq}, 32'h0);
        chk("async_reset_out_port", {24'h0, out_port}, 32'h0);
        chk("async_reset_readdata", readdata, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        bus_rd(2'd2, rd);
        chk("post_reset_status", rd, 32'h0);
        bus_rd(2'd1, rd);
        chk("post_reset_ctrl", rd, 32'h0);
        chk("post_reset_out_port", {24'h0, out_port}, 32'h0);
        chk("post_reset_req", {31'h0, req}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
